// File: rtl/PKG_pwm.sv
// PKG_pwm: shared enums and width defaults for the PWM carrier
package PKG_pwm;
  localparam int CNT_W_DEF = 16;
  localparam int DIV_W_DEF = 4;
  localparam int EVT_W_DEF = 3;
  typedef enum logic [1:0] {COUNT_UP, COUNT_DOWN, COUNT_UPDOWN, COUNT_HOLD} _count_mode;
  typedef enum logic [1:0] {NO_MASK, MIN_MASK, MAX_MASK, MINMAX_MASK} _mask_mode;
  typedef enum logic {CARR_OFF, CARR_ON} _carr_onoff;
  typedef enum logic {CLKDIV_OFF, CLKDIV_ON} _clkdiv_onoff;
  typedef enum logic {INT_OFF, INT_ON} _int_onoff;
endpackage

// File: rtl/pwm_clkdiv.sv
// pwm_clkdiv: prescaler, tick every div_val+1 clocks while enabled, every clock otherwise
module pwm_clkdiv import PKG_pwm::*; #(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  output logic             tick
);
  logic [DIV_W-1:0] cnt;
  // >= lets a shrunken div_val wrap on the very next clock
  assign tick = !en || cnt >= div_val;
  always_ff @(posedge clk)
    if (!rst_n || tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
endmodule

// File: rtl/pwm_carrier.sv
// pwm_carrier: shadowed up/down/up-down carrier counter with boundary events and interrupt divider
module pwm_carrier import PKG_pwm::*; #(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DIV_W = DIV_W_DEF,
  parameter int EVT_W = EVT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             carr_on,
  input  logic             clkdiv_on,
  input  logic [DIV_W-1:0] div_val,
  input  logic [1:0]       count_mode,
  input  logic [1:0]       mask_mode,
  input  logic [CNT_W-1:0] period,
  input  logic [EVT_W-1:0] evt_num,
  input  logic             int_on,
  output logic [CNT_W-1:0] cnt_out,
  output logic             dir_down,
  output logic             min_evt,
  output logic             max_evt,
  output logic             upd_evt,
  output logic             int_out
);
  _count_mode       mode;
  _mask_mode        mask;
  logic [CNT_W-1:0] prd;
  logic [CNT_W-1:0] nxt;
  logic [EVT_W-1:0] evt_cnt;
  logic             run;
  logic             tick;
  logic             ud_dn;
  logic             ud_nxt;
  logic             step_dn;
  logic             live;
  logic             hit_min;
  logic             hit_max;
  logic             evt;
  assign run = carr_on == CARR_ON;
  assign dir_down = mode == COUNT_DOWN || (mode == COUNT_UPDOWN && ud_dn);
  pwm_clkdiv #(.DIV_W(DIV_W)) u_clkdiv (
    .clk,
    .rst_n,
    .en(run && clkdiv_on == CLKDIV_ON),
    .div_val,
    .tick
  );
  // step direction re-derived from the count so a mode switch into up-down never runs away
  always_comb begin
    step_dn = ud_dn ? cnt_out != '0 : cnt_out >= prd;
    nxt = mode == COUNT_UP ? (cnt_out >= prd ? '0 : cnt_out + 1'b1)
        : mode == COUNT_DOWN ? ((cnt_out == '0 || cnt_out > prd) ? prd : cnt_out - 1'b1)
        : mode == COUNT_UPDOWN ? (prd == '0 ? '0 : step_dn ? cnt_out - 1'b1 : cnt_out + 1'b1)
        : cnt_out;
    ud_nxt = mode == COUNT_UPDOWN ? prd != '0 && (nxt == prd || (nxt != '0 && step_dn)) : ud_dn;
    live = tick && mode != COUNT_HOLD;
    hit_min = live && nxt == '0;
    hit_max = live && nxt == prd;
    evt = (hit_min && (mask == NO_MASK || mask == MAX_MASK)) || (hit_max && (mask == NO_MASK || mask == MIN_MASK));
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt_out <= '0;
      ud_dn <= 1'b0;
      prd <= '0;
      mode <= COUNT_UP;
      mask <= NO_MASK;
      evt_cnt <= '0;
      min_evt <= 1'b0;
      max_evt <= 1'b0;
      upd_evt <= 1'b0;
      int_out <= 1'b0;
    end else if (!run) begin
      prd <= period;
      mode <= _count_mode'(count_mode);
      mask <= _mask_mode'(mask_mode);
      cnt_out <= count_mode == COUNT_DOWN ? period : '0;
      ud_dn <= 1'b0;
      evt_cnt <= '0;
      min_evt <= 1'b0;
      max_evt <= 1'b0;
      upd_evt <= 1'b0;
      int_out <= 1'b0;
    end else begin
      if (tick) begin
        cnt_out <= nxt;
        ud_dn <= ud_nxt;
      end
      min_evt <= hit_min;
      max_evt <= hit_max;
      upd_evt <= evt;
      int_out <= evt && int_on == INT_ON && evt_cnt == evt_num;
      if (evt) begin
        evt_cnt <= evt_cnt == evt_num ? '0 : evt_cnt + 1'b1;
        prd <= period;
        mode <= _count_mode'(count_mode);
        mask <= _mask_mode'(mask_mode);
      end
    end
endmodule

// File: tb/tb_pwm_carrier.sv
// tb_pwm_carrier: directed scenarios checked every cycle against a phase-based carrier model
module tb_pwm_carrier;
  import PKG_pwm::*;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        carr_on = 0;
  logic        clkdiv_on = 0;
  logic        int_on = 0;
  logic [3:0]  div_val = 0;
  logic [1:0]  count_mode = 0;
  logic [1:0]  mask_mode = 0;
  logic [15:0] period = 0;
  logic [2:0]  evt_num = 0;
  logic [15:0] cnt_out;
  logic        dir_down, min_evt, max_evt, upd_evt, int_out;
  int checks = 0;
  int failures = 0;
  bit chk_en = 0;
  bit pin_en = 0;
  logic [20:0] pin;
  string pin_name;
  int m_cnt, m_p, m_pos, m_pre, m_ev, len;
  logic [1:0] m_mode, m_mask;
  bit m_min, m_max, m_upd, m_int, m_dir, tk;
  always #5 clk = ~clk;
  pwm_carrier dut (
    .clk(clk), .rst_n(rst_n), .carr_on(carr_on), .clkdiv_on(clkdiv_on), .div_val(div_val),
    .count_mode(count_mode), .mask_mode(mask_mode), .period(period), .evt_num(evt_num),
    .int_on(int_on), .cnt_out(cnt_out), .dir_down(dir_down), .min_evt(min_evt),
    .max_evt(max_evt), .upd_evt(upd_evt), .int_out(int_out)
  );
  // carrier value at a given position within one carrier period
  function automatic int val(input int pos, input int p, input logic [1:0] md);
    return md == COUNT_DOWN ? p - pos : (md == COUNT_UPDOWN && pos > p) ? 2 * p - pos : pos;
  endfunction
  always @(posedge clk) begin
    m_min = 0;
    m_max = 0;
    m_upd = 0;
    m_int = 0;
    if (!rst_n) begin
      m_cnt = 0; m_p = 0; m_mode = COUNT_UP; m_mask = NO_MASK; m_pos = 0; m_pre = 0; m_ev = 0;
    end else if (!carr_on) begin
      m_p = period; m_mode = count_mode; m_mask = mask_mode; m_pos = 0; m_pre = 0; m_ev = 0;
      m_cnt = val(0, m_p, m_mode);
    end else begin
      tk = !clkdiv_on || m_pre >= int'(div_val);
      m_pre = tk ? 0 : m_pre + 1;
      if (tk && m_mode != COUNT_HOLD) begin
        len = m_p == 0 ? 1 : m_mode == COUNT_UPDOWN ? 2 * m_p : m_p + 1;
        m_pos = m_pos + 1 >= len ? 0 : m_pos + 1;
        m_cnt = val(m_pos, m_p, m_mode);
        m_min = m_cnt == 0;
        m_max = m_cnt == m_p;
        if ((m_min && (m_mask == NO_MASK || m_mask == MAX_MASK)) || (m_max && (m_mask == NO_MASK || m_mask == MIN_MASK))) begin
          m_int = int_on && m_ev == int'(evt_num);
          m_ev = m_ev == int'(evt_num) ? 0 : m_ev + 1;
          m_upd = 1; m_p = period; m_mode = count_mode; m_mask = mask_mode;
          m_pos = m_mode == COUNT_DOWN ? (m_cnt > m_p ? 0 : m_p - m_cnt)
                : m_mode == COUNT_UPDOWN ? (m_cnt == 0 ? 0 : m_p) : m_cnt;
        end
      end
    end
    m_dir = m_mode == COUNT_DOWN || (m_mode == COUNT_UPDOWN && m_p != 0 && m_pos >= m_p);
  end
  always @(negedge clk) begin
    logic [20:0] dv, mv;
    dv = {cnt_out, dir_down, min_evt, max_evt, upd_evt, int_out};
    mv = {m_cnt[15:0], m_dir, m_min, m_max, m_upd, m_int};
    if (chk_en) begin
      checks++;
      if (dv !== mv) begin
        failures++;
        $display("FAIL model t=%0t dut cnt=%0d dir/min/max/upd/int=%b, want cnt=%0d %b", $time, dv[20:5], dv[4:0], mv[20:5], mv[4:0]);
      end
    end
    if (pin_en) begin
      checks += 2;
      if (dv !== pin) begin
        failures++;
        $display("FAIL %s dut cnt=%0d dir/min/max/upd/int=%b, want cnt=%0d %b", pin_name, dv[20:5], dv[4:0], pin[20:5], pin[4:0]);
      end
      if (mv !== pin) begin
        failures++;
        $display("FAIL %s model cnt=%0d flags=%b, want cnt=%0d %b", pin_name, mv[20:5], mv[4:0], pin[20:5], pin[4:0]);
      end
    end
  end
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic pin_at(input string name, input int c, input bit d, input bit mn, input bit mx, input bit up, input bit it);
    pin_name = name;
    pin = {c[15:0], d, mn, mx, up, it};
    pin_en = 1;
    @(negedge clk);
    #1 pin_en = 0;
  endtask
  task automatic setup(input logic [1:0] md, input logic [1:0] mk, input int p, input bit dv_on, input int dv);
    carr_on = 0; count_mode = md; mask_mode = mk; period = p[15:0]; clkdiv_on = dv_on; div_val = dv[3:0];
    cyc(2);
    carr_on = 1;
  endtask
  initial begin
    cyc(1);
    chk_en = 1;
    cyc(1);
    pin_at("reset_state", 0, 0, 0, 0, 0, 0);
    rst_n = 1;
    setup(COUNT_UP, NO_MASK, 4, 0, 0);
    cyc(4);
    pin_at("up_max_at_4", 4, 0, 0, 1, 1, 0);
    cyc(1);
    pin_at("up_wrap_min", 0, 0, 1, 0, 1, 0);
    setup(COUNT_UPDOWN, NO_MASK, 3, 1, 2);
    cyc(3);
    pin_at("ud_div_first", 1, 0, 0, 0, 0, 0);
    cyc(6);
    pin_at("ud_div_max", 3, 1, 0, 1, 1, 0);
    cyc(1);
    pin_at("ud_div_hold", 3, 1, 0, 0, 0, 0);
    cyc(8);
    pin_at("ud_div_min", 0, 0, 1, 0, 1, 0);
    setup(COUNT_UP, MIN_MASK, 10, 0, 0);
    cyc(3);
    period = 5;
    cyc(7);
    pin_at("mask_load_max", 10, 0, 0, 1, 1, 0);
    cyc(1);
    pin_at("mask_min_noload", 0, 0, 1, 0, 0, 0);
    cyc(5);
    pin_at("mask_new_period", 5, 0, 0, 1, 1, 0);
    evt_num = 3;
    int_on = 1;
    setup(COUNT_UPDOWN, NO_MASK, 2, 0, 0);
    cyc(8);
    pin_at("int_first", 0, 0, 1, 0, 1, 1);
    cyc(8);
    pin_at("int_second", 0, 0, 1, 0, 1, 1);
    int_on = 0;
    cyc(8);
    pin_at("int_gated", 0, 0, 1, 0, 1, 0);
    evt_num = 1;
    int_on = 1;
    carr_on = 0; count_mode = COUNT_DOWN; mask_mode = NO_MASK; period = 0; clkdiv_on = 0;
    cyc(2);
    pin_at("down_p0_off", 0, 1, 0, 0, 0, 0);
    carr_on = 1;
    cyc(1);
    pin_at("down_p0_tick1", 0, 1, 1, 1, 1, 0);
    cyc(1);
    pin_at("down_p0_tick2", 0, 1, 1, 1, 1, 1);
    int_on = 0;
    setup(COUNT_UP, NO_MASK, 15, 1, 5);
    cyc(4);
    div_val = 2;
    cyc(1);
    pin_at("div_shrink_wrap", 1, 0, 0, 0, 0, 0);
    cyc(3);
    pin_at("div_new_rate", 2, 0, 0, 0, 0, 0);
    setup(COUNT_UP, NO_MASK, 3, 0, 0);
    cyc(1);
    count_mode = COUNT_HOLD;
    cyc(2);
    cyc(3);
    pin_at("hold_mode", 3, 0, 0, 0, 0, 0);
    count_mode = COUNT_UP;
    setup(COUNT_UP, NO_MASK, 20, 0, 0);
    cyc(7);
    pin_at("pre_reset_7", 7, 0, 0, 0, 0, 0);
    rst_n = 0;
    cyc(1);
    pin_at("mid_reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1;
    cyc(1);
    pin_at("post_reset_p0", 0, 0, 1, 1, 1, 0);
    cyc(1);
    pin_at("post_reset_count", 1, 0, 0, 0, 0, 0);
    cyc(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
